instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: mem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port: mem_addr  output  32  fetch address, word-aligned.
REQ-006 SHALL have port: mem_ack  input  1  memory has placed the fetched word on mem_rdata this cycle.
REQ-007 SHALL have port: mem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port: instruction  output  32  latched instruction, to execution units.
REQ-009 SHALL have port: program_counter  output  32  address of the latched instruction.
REQ-010 SHALL have port: instr_valid  output  1  instruction/program_counter valid for execution.
REQ-011 SHALL have port: auipc_enable_n  output  1  active-low enable for the AUIPC unit.
REQ-012 SHALL have port: exec_done  input  1  the executing unit has finished and written back.
REQ-013 SHALL have port: branch_taken  input  1  with exec_done: next PC is branch_target.
REQ-014 SHALL have port: branch_target  input  32  redirect address.
REQ-015 SHALL have port: fetch_fault  output  1  misaligned redirect trap flag.

Function
REQ-016 SHALL implement states FETCH, EXECUTE, HALT.
REQ-017 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal the PC register, held stable until mem_ack.
REQ-018 In FETCH, mem_ack=1 SHALL latch mem_rdata into instruction, the PC into program_counter, and move to EXECUTE on the same edge; mem_req SHALL be 0 from the next cycle.
REQ-019 Fetch latency SHALL be 1 cycle after the mem_ack cycle; mem_ack held low SHALL stall FETCH indefinitely.
REQ-020 In EXECUTE, instr_valid SHALL be 1, and mem_ack SHALL be ignored.
REQ-021 In EXECUTE, auipc_enable_n SHALL be 0 iff instruction[6:0]==7'b0010111, else 1; in all other states it SHALL be 1.
REQ-022 In EXECUTE, exec_done=1 with branch_taken=0 SHALL set PC to PC+4, modulo 2^32, and return to FETCH.
REQ-023 In EXECUTE, exec_done=1 with branch_taken=1 SHALL set PC to branch_target, per REQ-029/030, and return to FETCH.
REQ-024 exec_done and branch_taken SHALL be ignored outside EXECUTE.
REQ-025 HALT SHALL be terminal until rst, with mem_req=0, instr_valid=0, fetch_fault=1.

Reset
REQ-026 rst=1 SHALL force, asynchronously: state FETCH, PC=RESET_PC, instruction=32'h0000_0013 (NOP), program_counter=RESET_PC, instr_valid=0, auipc_enable_n=1, fetch_fault=0.
REQ-027 Reset asserted mid-fetch or mid-execute SHALL abandon the transaction; a concurrent mem_ack or exec_done SHALL have no effect.
REQ-028 After rst falls, mem_req SHALL assert on the first clock cycle, with mem_addr=RESET_PC.

Configuration
REQ-029 With FETCH_MISALIGN_TRAP_EN defined, a redirect with branch_target[1:0]!=0 SHALL enter HALT instead of FETCH, leaving PC unchanged.
REQ-030 Without FETCH_MISALIGN_TRAP_EN, branch_target[1:0] SHALL be cleared to 2'b00, the redirect SHALL proceed, and fetch_fault SHALL be tied 0.

Verification
REQ-031 Reset release, mem_ack one cycle later with rdata 32'h0000_1297 -> mem_addr=0; then instruction=32'h0000_1297, program_counter=0, instr_valid=1, auipc_enable_n=0.
REQ-032 mem_ack held low for 5 cycles -> mem_req stays 1, mem_addr stays constant, instr_valid stays 0.
REQ-033 PC=32'hFFFF_FFFC, exec_done=1, branch_taken=0 -> next mem_addr=32'h0000_0000.
REQ-034 exec_done=1, branch_taken=1, target 32'h0000_0102 -> with macro: fetch_fault=1, mem_req=0 forever; without macro: mem_addr=32'h0000_0100.
REQ-035 rst pulsed in EXECUTE, coincident with exec_done -> instr_valid=0 immediately, then mem_addr=RESET_PC.
REQ-036 rdata 32'h0000_0033 (ADD) -> instr_valid=1 and auipc_enable_n=1 throughout EXECUTE.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: fetches one word, holds it for execution,
// then advances to PC+4 or redirects to a branch target.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- when defined, a redirect
// to a non-word-aligned target halts the fetcher with fetch_fault raised;
// when undefined, the target's low two bits are cleared and fetch_fault is 0.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] program_counter,
  output logic        instr_valid,
  output logic        auipc_enable_n,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        fetch_fault
);

  localparam logic [6:0]  OPCODE_AUIPC = 7'b0010111;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    EXECUTE = 2'b01,
    HALT    = 2'b10
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] instruction_r, instruction_s;
  logic [31:0] program_counter_r, program_counter_s;
  logic        mem_req_r, mem_req_s;
  logic        instr_valid_r, instr_valid_s;
  logic        auipc_enable_n_r, auipc_enable_n_s;
  logic        fetch_fault_r, fetch_fault_s;

  // Next-state, next-PC and next-output decode; outputs are precomputed so
  // they can be driven straight from flops.
  always_comb begin
    state_s           = state_r;
    pc_s              = pc_r;
    instruction_s     = instruction_r;
    program_counter_s = program_counter_r;
    case (state_r)
      FETCH: begin
        if (mem_ack) begin
          state_s           = EXECUTE;
          instruction_s     = mem_rdata;
          program_counter_s = pc_r;
        end else begin
          state_s = FETCH;
        end
      end
      EXECUTE: begin
        if (exec_done) begin
          if (branch_taken) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (branch_target[1:0] != 2'b00) begin
              state_s = HALT;
            end else begin
              pc_s    = branch_target;
              state_s = FETCH;
            end
`else
            pc_s    = {branch_target[31:2], 2'b00};
            state_s = FETCH;
`endif
          end else begin
            pc_s    = pc_r + 32'd4;
            state_s = FETCH;
          end
        end else begin
          state_s = EXECUTE;
        end
      end
      HALT: begin
        state_s = HALT;
      end
      default: begin
        // Unreachable encoding: restart fetching at the current PC.
        state_s = FETCH;
      end
    endcase

    mem_req_s     = (state_s == FETCH);
    instr_valid_s = (state_s == EXECUTE);
    if ((state_s == EXECUTE) && (instruction_s[6:0] == OPCODE_AUIPC)) begin
      auipc_enable_n_s = 1'b0;
    end else begin
      auipc_enable_n_s = 1'b1;
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    fetch_fault_s = (state_s == HALT);
`else
    fetch_fault_s = 1'b0;
`endif
  end

  // State, PC, latched instruction and registered output flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= FETCH;
      pc_r              <= RESET_PC;
      instruction_r     <= NOP_WORD;
      program_counter_r <= RESET_PC;
      mem_req_r         <= 1'b1;
      instr_valid_r     <= 1'b0;
      auipc_enable_n_r  <= 1'b1;
      fetch_fault_r     <= 1'b0;
    end else begin
      state_r           <= state_s;
      pc_r              <= pc_s;
      instruction_r     <= instruction_s;
      program_counter_r <= program_counter_s;
      mem_req_r         <= mem_req_s;
      instr_valid_r     <= instr_valid_s;
      auipc_enable_n_r  <= auipc_enable_n_s;
      fetch_fault_r     <= fetch_fault_s;
    end
  end

  assign mem_req         = mem_req_r;
  assign mem_addr        = pc_r;
  assign instruction     = instruction_r;
  assign program_counter = program_counter_r;
  assign instr_valid     = instr_valid_r;
  assign auipc_enable_n  = auipc_enable_n_r;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault     = fetch_fault_r;
`else
  assign fetch_fault     = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic [31:0] program_counter;
  logic        instr_valid;
  logic        auipc_enable_n;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        fetch_fault;

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction(instruction),
    .program_counter(program_counter), .instr_valid(instr_valid),
    .auipc_enable_n(auipc_enable_n), .exec_done(exec_done),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; exec_done = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    cyc; cyc;
    n_cmp++; if (instruction !== 32'h0000_0013) begin n_err++; $display("FAIL reset_instr got %h want %h", instruction, 32'h0000_0013); end
    n_cmp++; if (program_counter !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want %h", program_counter, 32'h0); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    n_cmp++; if (auipc_enable_n !== 1'b1) begin n_err++; $display("FAIL reset_auipc got %b want 1", auipc_enable_n); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b want 0", fetch_fault); end
    rst = 1'b0;
  endtask

  task automatic test_first_fetch;
    cyc;
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL first_req got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL first_addr got %h want %h", mem_addr, 32'h0); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_1297;
    cyc;
    mem_ack = 1'b0;
    n_cmp++; if (instruction !== 32'h0000_1297) begin n_err++; $display("FAIL auipc_instr got %h want %h", instruction, 32'h0000_1297); end
    n_cmp++; if (program_counter !== 32'h0) begin n_err++; $display("FAIL auipc_pc got %h want %h", program_counter, 32'h0); end
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL auipc_valid got %b want 1", instr_valid); end
    n_cmp++; if (auipc_enable_n !== 1'b0) begin n_err++; $display("FAIL auipc_en got %b want 0", auipc_enable_n); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL exec_req got %b want 0", mem_req); end
    exec_done = 1'b1;
    cyc;
    exec_done = 1'b0;
    n_cmp++; if (mem_addr !== 32'h0000_0004) begin n_err++; $display("FAIL seq_addr got %h want %h", mem_addr, 32'h4); end
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL seq_req got %b want 1", mem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL seq_valid got %b want 0", instr_valid); end
    n_cmp++; if (auipc_enable_n !== 1'b1) begin n_err++; $display("FAIL seq_auipc got %b want 1", auipc_enable_n); end
  endtask

  task automatic test_stall;
    // exec_done/branch_taken presented in FETCH must be ignored
    exec_done = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0040;
    for (int i = 0; i < 5; i++) begin
      cyc;
      n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL stall_req[%0d] got %b want 1", i, mem_req); end
      n_cmp++; if (mem_addr !== 32'h0000_0004) begin n_err++; $display("FAIL stall_addr[%0d] got %h want %h", i, mem_addr, 32'h4); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid[%0d] got %b want 0", i, instr_valid); end
    end
    exec_done = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_non_auipc;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0033;
    cyc;
    // mem_ack in EXECUTE must not reload the instruction
    mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL add_valid[%0d] got %b want 1", i, instr_valid); end
      n_cmp++; if (auipc_enable_n !== 1'b1) begin n_err++; $display("FAIL add_auipc[%0d] got %b want 1", i, auipc_enable_n); end
      n_cmp++; if (instruction !== 32'h0000_0033) begin n_err++; $display("FAIL add_instr[%0d] got %h want %h", i, instruction, 32'h33); end
      n_cmp++; if (program_counter !== 32'h0000_0004) begin n_err++; $display("FAIL add_pc[%0d] got %h want %h", i, program_counter, 32'h4); end
      cyc;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_wrap;
    exec_done = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    cyc;
    exec_done = 1'b0; branch_taken = 1'b0;
    n_cmp++; if (mem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL branch_addr got %h want %h", mem_addr, 32'hFFFF_FFFC); end
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL branch_req got %b want 1", mem_req); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    cyc;
    mem_ack = 1'b0;
    n_cmp++; if (program_counter !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc got %h want %h", program_counter, 32'hFFFF_FFFC); end
    exec_done = 1'b1;
    cyc;
    exec_done = 1'b0;
    n_cmp++; if (mem_addr !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_addr got %h want %h", mem_addr, 32'h0); end
  endtask

  task automatic test_misalign;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    cyc;
    mem_ack = 1'b0;
    exec_done = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0102;
    cyc;
    exec_done = 1'b0; branch_taken = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (fetch_fault !== 1'b1) begin n_err++; $display("FAIL halt_fault[%0d] got %b want 1", i, fetch_fault); end
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL halt_req[%0d] got %b want 0", i, mem_req); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL halt_valid[%0d] got %b want 0", i, instr_valid); end
      n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL halt_pc[%0d] got %h want %h", i, mem_addr, 32'h0); end
      cyc;
    end
    mem_ack = 1'b0;
`else
    n_cmp++; if (mem_addr !== 32'h0000_0100) begin n_err++; $display("FAIL align_addr got %h want %h", mem_addr, 32'h100); end
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL align_req got %b want 1", mem_req); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL align_fault got %b want 0", fetch_fault); end
`endif
  endtask

  task automatic test_reset_mid_exec;
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0000_1297;
    cyc;
    mem_ack = 1'b0;
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid got %b want 1", instr_valid); end
    rst = 1'b1; exec_done = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0080;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL async_valid got %b want 0", instr_valid); end
    n_cmp++; if (auipc_enable_n !== 1'b1) begin n_err++; $display("FAIL async_auipc got %b want 1", auipc_enable_n); end
    n_cmp++; if (instruction !== 32'h0000_0013) begin n_err++; $display("FAIL async_instr got %h want %h", instruction, 32'h13); end
    cyc;
    rst = 1'b0; exec_done = 1'b0; branch_taken = 1'b0;
    cyc;
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL post_rst_addr got %h want %h", mem_addr, 32'h0); end
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL post_rst_req got %b want 1", mem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_valid got %b want 0", instr_valid); end
    // reset during FETCH with a coincident mem_ack: nothing latched
    mem_ack = 1'b1; mem_rdata = 32'h0000_0033; rst = 1'b1;
    cyc;
    rst = 1'b0; mem_ack = 1'b0;
    cyc;
    n_cmp++; if (instruction !== 32'h0000_0013) begin n_err++; $display("FAIL fetch_rst_instr got %h want %h", instruction, 32'h13); end
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL fetch_rst_req got %b want 1", mem_req); end
  endtask

  initial begin
    test_reset;
    test_first_fetch;
    test_stall;
    test_non_auipc;
    test_wrap;
    test_misalign;
    test_reset_mid_exec;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
